// File: rtl/scan_pkg.sv
// Shared encodings and select-range constants for the scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] SEL_MIN = 3'd0;
    localparam logic [2:0] SEL_MAX = 3'd7;

    // Code the scan starts from for a given direction.
    function automatic logic [2:0] first_sel(input logic dir);
        return dir ? SEL_MAX : SEL_MIN;
    endfunction

    // Code the scan ends on for a given direction.
    function automatic logic [2:0] last_sel(input logic dir);
        return dir ? SEL_MIN : SEL_MAX;
    endfunction

endpackage

// File: rtl/scan_seq_if.sv
// Control/status bundle between a scan requester and the scan sequencer.
interface scan_seq_if;
    logic       start;
    logic       stop;
    logic       mode;
    logic       dir;
    logic       en;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic       wrap;

    modport master (
        output start, stop, mode, dir,
        input  en, sel, busy, done, wrap
    );

    modport slave (
        input  start, stop, mode, dir,
        output en, sel, busy, done, wrap
    );
endinterface

// File: rtl/scan_tick.sv
// Dwell counter: counts 0..DWELL-1 while run is high, pulses tick on the last count.
module scan_tick #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] cnt_q, cnt_d;

    // Tick marks the final cycle a select code is held.
    always_comb begin
        tick  = run && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (run) cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    end

    // Counter register; clear keeps it at zero whenever not scanning.
    always_ff @(posedge clk) begin
        if (rst || clear) cnt_q <= 8'd0;
        else              cnt_q <= cnt_d;
    end
endmodule

// File: rtl/scan_seq.sv
// Scan sequencer: steps a 3-bit select through 0..7 (or 7..0) holding each
// code DWELL cycles, for an external 3-to-8 decoder. One-shot or continuous.
module scan_seq
    import scan_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    scan_seq_if.slave  bus
);
    state_e     state_q;
    logic [2:0] sel_q;
    logic       en_q, busy_q, done_q, wrap_q;
    logic       mode_q, dir_q;
    logic       tick;

    // Counter runs only in RUN; held clear otherwise so every scan starts at 0.
    scan_tick #(.DWELL(DWELL)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q != ST_RUN),
        .run   (state_q == ST_RUN),
        .tick  (tick)
    );

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_MIN;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Stop outranks start when both arrive together.
                    if (bus.start && !bus.stop) begin
                        state_q <= ST_RUN;
                        mode_q  <= bus.mode;
                        dir_q   <= bus.dir;
                        sel_q   <= first_sel(bus.dir);
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_q <= ST_IDLE;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        if (sel_q == last_sel(dir_q) && !mode_q) begin
                            state_q <= ST_DONE;
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // 3-bit arithmetic gives the modulo-8 wrap for free.
                            sel_q  <= dir_q ? sel_q - 3'd1 : sel_q + 3'd1;
                            wrap_q <= (sel_q == last_sel(dir_q));
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.en   = en_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_seq.sv
// Directed bench for scan_seq at DWELL = 4, 2 and 1.
module tb_scan_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    scan_seq_if if4();
    scan_seq_if if2();
    scan_seq_if if1();

    scan_seq #(.DWELL(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    scan_seq #(.DWELL(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    scan_seq #(.DWELL(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Observed {en,busy,done,wrap,sel} per instance.
    logic [6:0] o4, o2, o1;
    assign o4 = {if4.en, if4.busy, if4.done, if4.wrap, if4.sel};
    assign o2 = {if2.en, if2.busy, if2.done, if2.wrap, if2.sel};
    assign o1 = {if1.en, if1.busy, if1.done, if1.wrap, if1.sel};

    function automatic logic [31:0] ev(logic en, logic busy, logic done, logic wrap, int sel);
        return {25'd0, en, busy, done, wrap, 3'(sel)};
    endfunction

    // Reference 3-to-8 decoder fed from the sequencer outputs.
    function automatic logic [7:0] dec38(logic en, logic [2:0] sel);
        return en ? (8'd1 << sel) : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    initial begin
        {if4.start, if4.stop, if4.mode, if4.dir} = 4'b0;
        {if2.start, if2.stop, if2.mode, if2.dir} = 4'b0;
        {if1.start, if1.stop, if1.mode, if1.dir} = 4'b0;
        repeat (2) @(negedge clk);
        chk("rst4", 32'(o4), 32'd0);
        chk("rst2", 32'(o2), 32'd0);
        chk("rst1", 32'(o1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // One-shot ascending; start/mode/dir disturbed mid-run must not matter.
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("up4", 32'(o4), ev(1, 1, 0, 0, i / 4));
            chk("dec4", 32'(dec38(if4.en, if4.sel)), 32'(8'd1 << (i / 4)));
            if (i == 10) begin if4.start = 1'b1; if4.mode = 1'b1; if4.dir = 1'b1; end
            if (i == 11) if4.start = 1'b0;
            @(negedge clk);
        end
        chk("done4", 32'(o4), ev(0, 0, 1, 0, 7));
        chk("dec4off", 32'(dec38(if4.en, if4.sel)), 32'd0);
        if4.start = 1'b1;                // ignored in DONE
        @(negedge clk);
        chk("idle4", 32'(o4), ev(0, 0, 0, 0, 7));
        if4.start = 1'b0;
        @(negedge clk);
        chk("idle4b", 32'(o4), ev(0, 0, 0, 0, 7));

        // Start and stop together in IDLE: no response.
        if4.start = 1'b1; if4.stop = 1'b1; if4.mode = 1'b0; if4.dir = 1'b1;
        @(negedge clk);
        if4.start = 1'b0; if4.stop = 1'b0;
        chk("ststp", 32'(o4), ev(0, 0, 0, 0, 7));
        @(negedge clk);
        chk("ststp2", 32'(o4), ev(0, 0, 0, 0, 7));

        // One-shot descending.
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("dn4", 32'(o4), ev(1, 1, 0, 0, 7 - i / 4));
            @(negedge clk);
        end
        chk("done4d", 32'(o4), ev(0, 0, 1, 0, 0));
        @(negedge clk);
        chk("idle4d", 32'(o4), ev(0, 0, 0, 0, 0));

        // Continuous ascending at DWELL=2, wrap then stop at sel=3.
        if2.start = 1'b1; if2.mode = 1'b1; if2.dir = 1'b0;
        @(negedge clk);
        if2.start = 1'b0;
        for (int i = 0; i < 23; i++) begin
            chk("cont2", 32'(o2), ev(1, 1, 0, i == 16, (i / 2) % 8));
            if (i == 22) if2.stop = 1'b1;
            @(negedge clk);
        end
        chk("stop2", 32'(o2), ev(0, 0, 0, 0, 3));
        if2.stop = 1'b0;
        @(negedge clk);
        chk("stop2b", 32'(o2), ev(0, 0, 0, 0, 3));

        // DWELL=1 one-shot ascending.
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("up1", 32'(o1), ev(1, 1, 0, 0, i));
            @(negedge clk);
        end
        chk("done1", 32'(o1), ev(0, 0, 1, 0, 7));
        @(negedge clk);
        chk("idle1", 32'(o1), ev(0, 0, 0, 0, 7));

        // Stop at the final code outranks the done transition.
        if1.start = 1'b1; if1.dir = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("dn1", 32'(o1), ev(1, 1, 0, 0, 7 - i));
            if (i == 7) if1.stop = 1'b1;
            @(negedge clk);
        end
        if1.stop = 1'b0;
        chk("stopfin", 32'(o1), ev(0, 0, 0, 0, 0));
        @(negedge clk);
        chk("stopfin2", 32'(o1), ev(0, 0, 0, 0, 0));

        // Reset mid-run at sel=5.
        if1.start = 1'b1; if1.dir = 1'b0;
        @(negedge clk);
        if1.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("pre_rst", 32'(o1), ev(1, 1, 0, 0, i));
            if (i == 5) rst = 1'b1;
            @(negedge clk);
        end
        chk("midrst", 32'(o1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst", 32'(o1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/scan_seq.md
SCAN_SEQ -- requirements
Module: scan_seq

Interface
REQ-001 Parameter DWELL, default 4, meaning clock cycles each select code is held; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in RUN and IDLE.
REQ-006 mode  input  1  0 = one-shot scan, 1 = continuous scan; latched on accepted start.
REQ-007 dir  input  1  0 = ascending (0->7), 1 = descending (7->0); latched on accepted start.
REQ-008 en  output  1  enable to downstream 3-to-8 decoder; high only while scanning.
REQ-009 sel  output  3  select code to downstream 3-to-8 decoder.
REQ-010 busy  output  1  high in RUN state.
REQ-011 done  output  1  one-cycle pulse on completion of a one-shot scan.
REQ-012 wrap  output  1  one-cycle pulse when sel wraps in continuous mode.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: start=1 and stop=0 -> RUN on the next edge; sel loads 0 (dir=0) or 7 (dir=1); en=1, busy=1, dwell count=0, all visible after that same edge.
REQ-016 IDLE: start=1 and stop=1 in the same cycle -> stop wins; the block remains in IDLE with outputs unchanged.
REQ-017 RUN: the dwell counter SHALL count 0..DWELL-1; on DWELL-1, sel advances by +1 (dir=0) or -1 (dir=1) modulo 8 and the counter clears, so every code is held exactly DWELL cycles.
REQ-018 DWELL=1: sel SHALL advance every cycle.
REQ-019 One-shot: on dwell expiry at the final code (7 ascending, 0 descending) -> DONE; en=0, busy=0, done=1 for one cycle; sel holds the final code.
REQ-020 DONE: return to IDLE on the next edge unconditionally; done=0; start in DONE is ignored.
REQ-021 Continuous: on dwell expiry at the final code, sel wraps (7->0 or 0->7), and wrap=1 during the first cycle of the wrapped code only.
REQ-022 stop=1 in RUN -> IDLE on the next edge; en=0, busy=0, done=0, wrap=0; sel holds its last value. Stop has priority over dwell expiry and over the final-code transition.
REQ-023 start in RUN SHALL be ignored; the sequence is unaffected.
REQ-024 One-shot scan length SHALL be exactly 8*DWELL cycles with en=1, followed by one done cycle.
REQ-025 mode and dir changes after an accepted start SHALL have no effect until the next accepted start.

Reset
REQ-026 rst=1 at an edge -> IDLE, sel=0, en=0, busy=0, done=0, wrap=0, dwell count=0, latched mode/dir=0.
REQ-027 rst SHALL override start, stop and every in-progress state, including mid-RUN and DONE.

Structure
REQ-028 State encoding (IDLE=0, RUN=1, DONE=2), SEL_MIN=0 and SEL_MAX=7 SHALL live in the shared package scan_pkg.
REQ-029 The dwell counter SHALL be the sub-module scan_tick (inputs: clk, rst, clear, run; output: tick pulse on count DWELL-1).
REQ-030 The 3-to-8 decoder SHALL remain a separate block; scan_seq drives its enable and 3-bit select and does not instantiate it.

Verification
REQ-031 DWELL=4, mode=0, dir=0, start pulse -> sel 0,1,...,7 with each code held 4 cycles and en=1 for 32 cycles; then done=1 for 1 cycle, en=0, sel=7, then IDLE.
REQ-032 DWELL=4, mode=0, dir=1 -> sel 7 down to 0, each code held 4 cycles; done pulse; sel holds 0.
REQ-033 DWELL=2, mode=1, dir=0 -> after sel=7 for 2 cycles, sel=0 with wrap=1 for exactly 1 cycle; scan continues; stop at sel=3 -> next cycle en=0, busy=0, sel=3, no done.
REQ-034 DWELL=1 one-shot -> sel changes every cycle, 8 cycles en=1, then done.
REQ-035 start+stop in the same cycle in IDLE -> no response; start re-pulsed mid-RUN -> sequence unchanged; rst mid-RUN at sel=5 -> all outputs at reset values after that edge.
REQ-036 With a 3-to-8 decoder attached: while en=1, the decoder output equals 1<<sel (exactly one bit set); while en=0, the decoder output is 0.
